// File: rtl/line_fill_pkg.sv
// ============================================================================
// line_fill_pkg : shared types, read tag and beat-geometry helpers.
// Revision 1.0
// ============================================================================
`default_nettype none

package line_fill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } fill_state_e;

  // {read, memory target, reserved}
  localparam logic [12:0] FILL_READ_TAG = {1'b1, 4'b0001, 8'h00};

  function automatic int calc_beats(input int line_bytes, input int data_width);
    return (line_bytes * 8) / data_width;
  endfunction

  function automatic int calc_idx_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int DEF_BEATS = calc_beats(64, 64);
  localparam int DEF_IDX_W = calc_idx_w(DEF_BEATS);

endpackage

`default_nettype wire

// File: rtl/line_fill_buffer.sv
// ============================================================================
// line_fill_buffer : beat-indexed line register, cleared at the start of a fill.
// Revision 1.0
// ============================================================================
`default_nettype none

module line_fill_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int BEATS      = 8,
  parameter int IDX_W      = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_idx,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  output logic [BEATS*DATA_WIDTH-1:0] line
);

  for (genvar k = 0; k < BEATS; k++) begin : g_slot
    logic [DATA_WIDTH-1:0] slot_q;
    logic [DATA_WIDTH-1:0] slot_d;

    always_comb begin
      slot_d = slot_q;
      if (clr) begin
        slot_d = '0;
      end else if (wr_en && (wr_idx == IDX_W'(k))) begin
        slot_d = wr_data;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        slot_q <= '0;
      end else begin
        slot_q <= slot_d;
      end
    end

    assign line[k*DATA_WIDTH +: DATA_WIDTH] = slot_q;
  end

endmodule

`default_nettype wire

// File: rtl/line_fill_master.sv
// ============================================================================
// line_fill_master : one-outstanding I-cache line fill over a Sysbus read burst.
// Optional watchdog enabled by LINE_FILL_TIMEOUT_EN.        Revision 1.0
// ============================================================================
`default_nettype none

module line_fill_master
  import line_fill_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BYTES     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fill_req_valid,
  output logic                        fill_req_ready,
  input  logic [BUS_DATA_WIDTH-1:0]   fill_req_addr,
  output logic                        fill_resp_valid,
  input  logic                        fill_resp_ready,
  output logic [LINE_BYTES*8-1:0]     fill_resp_line,
  output logic [BUS_DATA_WIDTH-1:0]   fill_resp_addr,
  output logic                        fill_resp_err,
  output logic [BUS_DATA_WIDTH-1:0]   bus_req,
  output logic                        bus_reqcyc,
  output logic [BUS_TAG_WIDTH-1:0]    bus_reqtag,
  input  logic                        bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0]   bus_resp,
  input  logic                        bus_respcyc,
  output logic                        bus_respack,
  input  logic [BUS_TAG_WIDTH-1:0]    bus_resptag
);

  localparam int BEATS = calc_beats(LINE_BYTES, BUS_DATA_WIDTH);
  localparam int IDX_W = calc_idx_w(BEATS);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

  fill_state_e               state_q, state_d;
  logic [BUS_DATA_WIDTH-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic                      req_ready_q, req_ready_d;
  logic                      reqcyc_q, reqcyc_d;
  logic                      resp_valid_q, resp_valid_d;
  logic                      beat_w;
  logic                      accept_w;
  logic [BUS_DATA_WIDTH-1:0] aligned_w;

  assign beat_w    = (state_q == RESP) && bus_respcyc;
  assign accept_w  = (state_q == IDLE) && fill_req_valid;
  assign aligned_w = (fill_req_addr >> OFF_W) << OFF_W;

`ifdef LINE_FILL_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            unused_ok;

  assign unused_ok = ^{bus_resptag, fill_req_addr[OFF_W-1:0]};
`else
  logic unused_ok;

  assign unused_ok = ^{bus_resptag, fill_req_addr[OFF_W-1:0], TIMEOUT_CYCLES[0]};
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (fill_req_valid) begin
          addr_d  = aligned_w;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus_reqack) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (beat_w) begin
          // Counter parks on the last slot so it never wraps into another line.
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (fill_resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef LINE_FILL_TIMEOUT_EN
    wd_d  = wd_q;
    err_d = err_q;
    if (accept_w) begin
      wd_d = '0;
    end else if ((state_q == REQ) || (state_q == RESP)) begin
      wd_d = beat_w ? '0 : wd_q + 1'b1;
      if ((wd_q == WD_LIMIT) && !beat_w) begin
        state_d = DONE;
        err_d   = 1'b1;
      end
    end
    if ((state_q == DONE) && fill_resp_ready) begin
      err_d = 1'b0;
    end
`endif

    req_ready_d  = (state_d == IDLE);
    reqcyc_d     = (state_d == REQ);
    resp_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      reqcyc_q     <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      reqcyc_q     <= reqcyc_d;
      resp_valid_q <= resp_valid_d;
    end
  end

`ifdef LINE_FILL_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign fill_resp_err = err_q;
`else
  assign fill_resp_err = 1'b0;
`endif

  line_fill_buffer #(
    .DATA_WIDTH (BUS_DATA_WIDTH),
    .BEATS      (BEATS),
    .IDX_W      (IDX_W)
  ) u_buffer (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept_w),
    .wr_en   (beat_w),
    .wr_idx  (cnt_q),
    .wr_data (bus_resp),
    .line    (fill_resp_line)
  );

  assign fill_req_ready  = req_ready_q;
  assign fill_resp_valid = resp_valid_q;
  assign fill_resp_addr  = addr_q;
  assign bus_reqcyc      = reqcyc_q;
  assign bus_req         = reqcyc_q ? addr_q : '0;
  assign bus_reqtag      = reqcyc_q ? BUS_TAG_WIDTH'(FILL_READ_TAG) : '0;
  assign bus_respack     = beat_w;

endmodule

`default_nettype wire

// File: tb/tb_line_fill_master.sv
// ============================================================================
// tb_line_fill_master : directed stimulus with a queue-based response monitor.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_line_fill_master;

`ifdef LINE_FILL_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif
  localparam logic [12:0] TAG_EXP = 13'h1100;

  logic         clk = 1'b0;
  logic         reset;
  logic         fill_req_valid;
  logic         fill_req_ready;
  logic [63:0]  fill_req_addr;
  logic         fill_resp_valid;
  logic         fill_resp_ready;
  logic [511:0] fill_resp_line;
  logic [63:0]  fill_resp_addr;
  logic         fill_resp_err;
  logic [63:0]  bus_req;
  logic         bus_reqcyc;
  logic [12:0]  bus_reqtag;
  logic         bus_reqack;
  logic [63:0]  bus_resp;
  logic         bus_respcyc;
  logic         bus_respack;
  logic [12:0]  bus_resptag;

  typedef struct {
    logic [511:0] line;
    logic [63:0]  addr;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  line_fill_master #(
    .BUS_DATA_WIDTH (64),
    .BUS_TAG_WIDTH  (13),
    .LINE_BYTES     (64),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fill_req_valid  (fill_req_valid),
    .fill_req_ready  (fill_req_ready),
    .fill_req_addr   (fill_req_addr),
    .fill_resp_valid (fill_resp_valid),
    .fill_resp_ready (fill_resp_ready),
    .fill_resp_line  (fill_resp_line),
    .fill_resp_addr  (fill_resp_addr),
    .fill_resp_err   (fill_resp_err),
    .bus_req         (bus_req),
    .bus_reqcyc      (bus_reqcyc),
    .bus_reqtag      (bus_reqtag),
    .bus_reqack      (bus_reqack),
    .bus_resp        (bus_resp),
    .bus_respcyc     (bus_respcyc),
    .bus_respack     (bus_respack),
    .bus_resptag     (bus_resptag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] mk_line(input logic [63:0] base);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k);
    return l;
  endfunction

  task automatic push_exp(input logic [63:0] base, input logic [63:0] addr, input logic err);
    exp_t e;
    e.line = mk_line(base);
    e.addr = addr;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  // Response monitor: pops one expectation per completed handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && fill_resp_valid && fill_resp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_resp: got addr %0h expected no response", fill_resp_addr);
        end else begin
          e = exp_q.pop_front();
          chk("resp_addr", fill_resp_addr, e.addr);
          chk("resp_err", fill_resp_err, e.err);
          if (!e.err) chk("resp_line", fill_resp_line, e.line);
        end
      end
    end
  end

  task automatic wait_req_ready();
    int n = 0;
    while (!fill_req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("req_ready_wait", fill_req_ready, 1);
  endtask

  task automatic issue(input logic [63:0] addr);
    wait_req_ready();
    fill_req_valid = 1'b1;
    fill_req_addr  = addr;
    tick();
    fill_req_valid = 1'b0;
  endtask

  // Serves one burst after the request has been accepted.
  task automatic serve(input int ack_dly, input int gap, input logic [63:0] base,
                       input logic [63:0] exp_addr, output int acks);
    acks = 0;
    chk("reqcyc_up", bus_reqcyc, 1);
    chk("req_addr", bus_req, exp_addr);
    chk("req_tag", bus_reqtag, TAG_EXP);
    for (int d = 0; d < ack_dly; d++) begin
      bus_respcyc = 1'b1;
      bus_resp    = 64'hDEAD_BEEF_0000_0000;
      #1;
      chk("no_ack_in_req", bus_respack, 0);
      tick();
      chk("reqcyc_hold", bus_reqcyc, 1);
      chk("req_addr_hold", bus_req, exp_addr);
    end
    bus_respcyc = 1'b0;
    bus_reqack  = 1'b1;
    tick();
    bus_reqack = 1'b0;
    chk("reqcyc_drop", bus_reqcyc, 0);
    for (int k = 0; k < 8; k++) begin
      for (int g = 1; g < gap; g++) begin
        bus_respcyc = 1'b0;
        #1;
        if (bus_respack) acks++;
        tick();
      end
      bus_respcyc = 1'b1;
      bus_resp    = base + 64'(k);
      #1;
      if (bus_respack) acks++;
      chk("valid_early", fill_resp_valid, 0);
      tick();
    end
    bus_respcyc = 1'b0;
    chk("valid_after_burst", fill_resp_valid, 1);
  endtask

  initial begin
    int acks;
    reset           = 1'b0;
    fill_req_valid  = 1'b0;
    fill_req_addr   = '0;
    fill_resp_ready = 1'b1;
    bus_reqack      = 1'b0;
    bus_resp        = '0;
    bus_respcyc     = 1'b1;
    bus_resptag     = '0;

    // Reset values, with the bus streaming into a reset block.
    repeat (2) tick();
    chk("rst_req_ready", fill_req_ready, 1);
    chk("rst_resp_valid", fill_resp_valid, 0);
    chk("rst_resp_err", fill_resp_err, 0);
    chk("rst_reqcyc", bus_reqcyc, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_reqtag", bus_reqtag, 0);
    chk("rst_respack", bus_respack, 0);
    bus_respcyc = 1'b0;
    reset = 1'b1;
    tick();

    // Basic fill: valid appears on the 10th edge counting the accept edge.
    push_exp(64'h0, 64'h1200, 1'b0);
    issue(64'h1234);
    serve(0, 1, 64'h0, 64'h1200, acks);
    chk("basic_acks", acks, 8);
    tick();
    chk("basic_done_valid", fill_resp_valid, 0);
    chk("basic_ready_back", fill_req_ready, 1);

    // Delayed reqack; stray respcyc in REQ is neither acked nor stored.
    push_exp(64'h100, 64'h40000, 1'b0);
    issue(64'h4_0008);
    serve(5, 1, 64'h100, 64'h40000, acks);
    chk("dly_acks", acks, 8);
    tick();

    // Beats every third cycle.
    push_exp(64'hA0, 64'hFFFF_FFFF_FFFF_FFC0, 1'b0);
    issue(64'hFFFF_FFFF_FFFF_FFC1);
    serve(0, 3, 64'hA0, 64'hFFFF_FFFF_FFFF_FFC0, acks);
    chk("gap_acks", acks, 8);
    tick();

    // Backpressure, then a request pending at the handshake.
    fill_resp_ready = 1'b0;
    push_exp(64'h200, 64'h2040, 1'b0);
    issue(64'h2040);
    serve(0, 1, 64'h200, 64'h2040, acks);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid", fill_resp_valid, 1);
      chk("bp_req_ready", fill_req_ready, 0);
      chk("bp_addr", fill_resp_addr, 64'h2040);
      chk("bp_line", fill_resp_line, mk_line(64'h200));
    end
    fill_resp_ready = 1'b1;
    fill_req_valid  = 1'b1;
    fill_req_addr   = 64'h3010;
    tick();
    chk("bp_ready_after_hs", fill_req_ready, 1);
    chk("bp_valid_after_hs", fill_resp_valid, 0);
    push_exp(64'h300, 64'h3000, 1'b0);
    tick();
    fill_req_valid = 1'b0;
    serve(0, 1, 64'h300, 64'h3000, acks);
    tick();

    // Reset after beat 3 while memory keeps streaming.
    issue(64'h5000);
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_respcyc = 1'b1;
      bus_resp    = 64'h500 + 64'(k);
      tick();
    end
    reset = 1'b0;
    #1;
    chk("mid_rst_respack", bus_respack, 0);
    chk("mid_rst_req_ready", fill_req_ready, 1);
    chk("mid_rst_reqcyc", bus_reqcyc, 0);
    chk("mid_rst_valid", fill_resp_valid, 0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("post_rst_respack", bus_respack, 0);
    tick();
    chk("post_rst_respack2", bus_respack, 0);
    chk("post_rst_valid", fill_resp_valid, 0);
    bus_respcyc = 1'b0;
    push_exp(64'h600, 64'h6000, 1'b0);
    issue(64'h6020);
    serve(0, 1, 64'h600, 64'h6000, acks);
    chk("post_rst_acks", acks, 8);
    tick();

`ifdef LINE_FILL_TIMEOUT_EN
    // Two beats, then silence: timeout after 16 idle cycles.
    push_exp(64'h0, 64'h7000, 1'b1);
    issue(64'h7000);
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus_respcyc = 1'b1;
      bus_resp    = 64'h700 + 64'(k);
      tick();
    end
    bus_respcyc = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_not_yet", fill_resp_valid, 0);
    end
    tick();
    chk("to_valid", fill_resp_valid, 1);
    chk("to_err", fill_resp_err, 1);
    tick();
    chk("to_err_clear", fill_resp_err, 0);
`endif

    repeat (2) tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
